// File: rtl/serial_paralelo_rx.sv
// serial_paralelo_rx: receive-side deserializer for one lane.
// Hunts for the COMMA symbol with a bit-sliding window. Locks after
// LOCK_COUNT consecutive commas at the same word phase. Once locked it
// emits one parallel byte per WIDTH serial bits and treats commas as idle.
// Optional feature: define SERPAR_LOCK_LOSS_EN to drop lock after 16
// consecutive non-comma word boundaries.
module serial_paralelo_rx #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] COMMA      = 8'hBC,
  parameter int               LOCK_COUNT = 4
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             byte_stb,
  output logic             active,
  output logic             comma_seen
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sr, sr_next;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_nx;
  logic [3:0]       bc_cnt, bc_cnt_nx, bc_inc;
  logic [WIDTH-1:0] data_nx;
  logic             valid_nx, stb_nx, active_nx, cs_nx;
  logic             boundary, is_comma;
`ifdef SERPAR_LOCK_LOSS_EN
  logic [4:0]       gap_cnt, gap_nx;
`endif

  assign sr_next  = {sr[WIDTH-2:0], data_in};
  assign boundary = (bit_cnt == CNT_W'(WIDTH - 1));
  assign is_comma = (sr_next == COMMA);
  assign bc_inc   = bc_cnt + 4'd1;

  // Next-state and next-output decode for the alignment FSM.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_nx   = state;
    bit_cnt_nx = boundary ? '0 : bit_cnt + CNT_W'(1);
    bc_cnt_nx  = bc_cnt;
    data_nx    = data_out;
    valid_nx   = valid_out;
    stb_nx     = 1'b0;
    cs_nx      = 1'b0;
    active_nx  = active;
`ifdef SERPAR_LOCK_LOSS_EN
    gap_nx     = gap_cnt;
`endif
    unique case (state)
      SEARCH: begin
        // Sliding window: any bit phase may hold the first comma.
        bit_cnt_nx = '0;
        if (is_comma) begin
          bc_cnt_nx = 4'd1;
          if (LOCK_COUNT == 1) begin
            state_nx  = LOCKED;
            active_nx = 1'b1;
          end else begin
            state_nx = ALIGN;
          end
        end
      end
      ALIGN: begin
        // Only commas on the phase fixed by the first one count.
        if (boundary) begin
          if (is_comma) begin
            cs_nx     = 1'b1;
            bc_cnt_nx = bc_inc;
            if (bc_inc == 4'(LOCK_COUNT)) begin
              state_nx  = LOCKED;
              active_nx = 1'b1;
            end
          end else begin
            bc_cnt_nx = '0;
            state_nx  = SEARCH;
          end
        end
      end
      LOCKED: begin
        if (boundary) begin
          stb_nx = 1'b1;
          if (is_comma) begin
            // Idle symbol: keep the last payload byte, flag it stale.
            cs_nx    = 1'b1;
            valid_nx = 1'b0;
`ifdef SERPAR_LOCK_LOSS_EN
            gap_nx   = '0;
`endif
          end else begin
`ifdef SERPAR_LOCK_LOSS_EN
            if (gap_cnt == 5'd15) begin
              // Sixteenth comma-free word in a row: alignment is suspect.
              state_nx   = SEARCH;
              active_nx  = 1'b0;
              valid_nx   = 1'b0;
              bc_cnt_nx  = '0;
              bit_cnt_nx = '0;
              gap_nx     = '0;
            end else begin
              gap_nx   = gap_cnt + 5'd1;
              data_nx  = sr_next;
              valid_nx = 1'b1;
            end
`else
            data_nx  = sr_next;
            valid_nx = 1'b1;
`endif
          end
        end
      end
      default: state_nx = SEARCH;
    endcase
  end

  // State, shift register, counters and registered outputs.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state      <= SEARCH;
      sr         <= '0;
      bit_cnt    <= '0;
      bc_cnt     <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      byte_stb   <= 1'b0;
      active     <= 1'b0;
      comma_seen <= 1'b0;
`ifdef SERPAR_LOCK_LOSS_EN
      gap_cnt    <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state      <= state_nx;
      sr         <= sr_next;
      bit_cnt    <= bit_cnt_nx;
      bc_cnt     <= bc_cnt_nx;
      data_out   <= data_nx;
      valid_out  <= valid_nx;
      byte_stb   <= stb_nx;
      active     <= active_nx;
      comma_seen <= cs_nx;
`ifdef SERPAR_LOCK_LOSS_EN
      gap_cnt    <= gap_nx;
`endif
    end
  end

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Self-checking bench for serial_paralelo_rx. A bit-history model tracks
// the word phase by bit index arithmetic and is compared on every falling
// edge; directed scenarios add literal expectations.
// Honours SERPAR_LOCK_LOSS_EN when compiled with it.
module tb_serial_paralelo_rx;

  localparam int         LOCK  = 4;
  localparam logic [7:0] COMMA = 8'hBC;

  logic       clk_32f = 1'b0;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out, byte_stb, active, comma_seen;

  int n_cmp = 0;
  int n_bad = 0;

  serial_paralelo_rx #(.WIDTH(8), .COMMA(COMMA), .LOCK_COUNT(LOCK)) dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .data_in    (data_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .byte_stb   (byte_stb),
    .active     (active),
    .comma_seen (comma_seen)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_SEARCH, M_ALIGN, M_LOCKED} mode_t;
  mode_t      m_mode;
  bit         hist[$];
  int         nbits, anchor, commas, gap;
  logic [7:0] m_data;
  logic       m_valid, m_stb, m_active, m_cs;

  // Model advances on each sampled bit; words sit every 8 bits after anchor.
  always @(posedge clk_32f or negedge reset) begin
    logic [7:0] w;
    if (!reset) begin
      hist.delete();
      m_mode = M_SEARCH; nbits = 0; anchor = 0; commas = 0; gap = 0;
      m_data = '0; m_valid = 0; m_stb = 0; m_active = 0; m_cs = 0;
    end else begin
      hist.push_back(data_in);
      if (hist.size() > 8) void'(hist.pop_front());
      nbits++;
      w = '0;
      foreach (hist[i]) w = {w[6:0], hist[i]};
      m_stb = 0; m_cs = 0;
      case (m_mode)
        M_SEARCH: if (w == COMMA) begin
          anchor = nbits; commas = 1; m_mode = M_ALIGN;
        end
        M_ALIGN: if ((nbits - anchor) % 8 == 0) begin
          if (w == COMMA) begin
            m_cs = 1; commas++;
            if (commas == LOCK) begin m_mode = M_LOCKED; m_active = 1; gap = 0; end
          end else m_mode = M_SEARCH;
        end
        M_LOCKED: if ((nbits - anchor) % 8 == 0) begin
          m_stb = 1;
          if (w == COMMA) begin
            m_cs = 1; m_valid = 0; gap = 0;
          end else begin
            gap++;
`ifdef SERPAR_LOCK_LOSS_EN
            if (gap == 16) begin
              m_mode = M_SEARCH; m_active = 0; m_valid = 0; gap = 0;
            end else begin
              m_data = w; m_valid = 1;
            end
`else
            m_data = w; m_valid = 1;
`endif
          end
        end
        default: m_mode = M_SEARCH;
      endcase
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk_32f) begin
    check("data_out",   32'(data_out),   32'(m_data));
    check("valid_out",  32'(valid_out),  32'(m_valid));
    check("byte_stb",   32'(byte_stb),   32'(m_stb));
    check("active",     32'(active),     32'(m_active));
    check("comma_seen", 32'(comma_seen), 32'(m_cs));
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_bit(input logic b);
    @(negedge clk_32f);
    data_in = b;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  // Wait for the edge that samples the last driven bit, then settle.
  task automatic after_edge();
    @(posedge clk_32f);
    #1;
  endtask

  initial begin
    reset   = 1'b0;
    data_in = 1'b0;
    repeat (3) @(posedge clk_32f);
    @(negedge clk_32f);
    reset = 1'b1;

    // Idle line after reset: nothing may happen.
    repeat (64) send_bit(1'b0);
    after_edge();
    check("idle_active", 32'(active), 32'd0);
    check("idle_data",   32'(data_out), 32'd0);
    check("idle_valid",  32'(valid_out), 32'd0);

    // Three commas then a non-comma: alignment abandoned.
    repeat (3) send_byte(COMMA);
    send_byte(8'h55);
    after_edge();
    check("short_run_active", 32'(active), 32'd0);

    // Four commas lock on the edge sampling the last bit.
    repeat (3) send_byte(COMMA);
    after_edge();
    check("three_commas_active", 32'(active), 32'd0);
    send_byte(COMMA);
    after_edge();
    check("lock_active", 32'(active), 32'd1);
    check("lock_comma_seen", 32'(comma_seen), 32'd1);

    // Locked payload stream.
    send_byte(8'hA3);
    after_edge();
    check("a3_data",  32'(data_out),  32'hA3);
    check("a3_valid", 32'(valid_out), 32'd1);
    check("a3_stb",   32'(byte_stb),  32'd1);
    send_byte(8'h7E);
    after_edge();
    check("7e_data",  32'(data_out),  32'h7E);
    check("7e_valid", 32'(valid_out), 32'd1);
    send_byte(COMMA);
    after_edge();
    check("idle_comma_valid", 32'(valid_out), 32'd0);
    check("idle_comma_data",  32'(data_out),  32'h7E);
    check("idle_comma_stb",   32'(byte_stb),  32'd1);

    // Random locked traffic with sprinkled idles.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(3) == 0) send_byte(COMMA);
      else send_byte(8'($urandom));
    end

    // Relock from scratch so the mid-byte reset hits a locked receiver.
    repeat (LOCK) send_byte(COMMA);
    send_byte(8'h3C);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    @(posedge clk_32f);
    #2 reset = 1'b0;
    #1;
    check("arst_data",   32'(data_out),   32'd0);
    check("arst_valid",  32'(valid_out),  32'd0);
    check("arst_stb",    32'(byte_stb),   32'd0);
    check("arst_active", 32'(active),     32'd0);
    check("arst_cs",     32'(comma_seen), 32'd0);
    repeat (2) @(posedge clk_32f);
    @(negedge clk_32f);
    reset = 1'b1;

    // Three random bits shift the word phase; four commas still required.
    for (int i = 0; i < 3; i++) send_bit(1'($urandom));
    repeat (3) send_byte(COMMA);
    after_edge();
    check("relock_three_active", 32'(active), 32'd0);
    send_byte(COMMA);
    after_edge();
    check("relock_active", 32'(active), 32'd1);
    send_byte(8'h11);
    after_edge();
    check("offset_data",  32'(data_out),  32'h11);
    check("offset_valid", 32'(valid_out), 32'd1);

    // Long comma-free run.
    send_byte(COMMA);
    repeat (15) send_byte(8'h00);
    after_edge();
    check("gap15_active", 32'(active), 32'd1);
    send_byte(8'h00);
    after_edge();
    check("gap16_stb", 32'(byte_stb), 32'd1);
`ifdef SERPAR_LOCK_LOSS_EN
    check("gap16_active", 32'(active),    32'd0);
    check("gap16_valid",  32'(valid_out), 32'd0);
`else
    check("gap16_active", 32'(active),    32'd1);
    check("gap16_valid",  32'(valid_out), 32'd1);
`endif

    // Random bit stream with occasional comma bursts on arbitrary phases.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(19) == 0) repeat ($urandom_range(5, 1)) send_byte(COMMA);
      else send_bit(1'($urandom));
    end
    after_edge();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
